// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// result_o = {remainder, quotient}; stall_o freezes the pipeline while busy.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stall_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     rem_nx;
    logic [WIDTH-1:0]     quo_nx;
    logic [WIDTH-1:0]     op1_abs;
    logic [WIDTH-1:0]     op2_abs;

    // One restoring step; the extra top bit of diff is the borrow.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvsr_q};
        if (!diff[WIDTH]) begin
            rem_nx = diff[WIDTH-1:0];
            quo_nx = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[WIDTH-1:0];
            quo_nx = {quo_q[WIDTH-2:0], 1'b0};
        end
        op1_abs = (signed_i && opdata1_i[WIDTH-1]) ? (-opdata1_i) : opdata1_i;
        op2_abs = (signed_i && opdata2_i[WIDTH-1]) ? (-opdata2_i) : opdata2_i;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = S_DIVZERO;
                    end else begin
                        quo_d     = op1_abs;
                        dvsr_d    = op2_abs;
                        rem_d     = '0;
                        count_d   = '0;
                        neg_quo_d = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_d = signed_i & opdata1_i[WIDTH-1];
                        state_d   = S_ON;
                    end
                end
            end
            S_DIVZERO: begin
                result_d = '0;
                state_d  = S_END;
            end
            S_ON: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d   = rem_nx;
                    quo_d   = quo_nx;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        result_d = {neg_rem_q ? (-rem_nx) : rem_nx,
                                    neg_quo_q ? (-quo_nx) : quo_nx};
                        state_d  = S_END;
                    end
                end
            end
            S_END: begin
                if (!start_i || annul_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_END);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    // Combinational so an exception flush drops the freeze in the same cycle.
    assign stall_o  = start_i & ~annul_i & (state_q != S_END);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (WIDTH=32).
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .stall_o   (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide, check latency, stall profile, result and hold behaviour.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int lat, input int hold);
        int cyc;
        int stall_bad;
        int hold_bad;
        start_i   = 1'b1;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        #1;
        check({tag, "_stall_c0"}, 64'(stall_o), 64'd1);
        cyc = 0;
        stall_bad = 0;
        while (cyc < 40) begin
            step();
            cyc++;
            opdata1_i = 32'hDEAD_BEEF;
            opdata2_i = 32'h0000_0001;
            signed_i  = ~sgn;
            if (ready_o) break;
            if (!stall_o) stall_bad++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        check({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
        check({tag, "_result"}, result_o, exp);
        check({tag, "_stall_end"}, 64'(stall_o), 64'd0);
        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            step();
            if (result_o !== exp || stall_o !== 1'b0 || ready_o !== 1'b1) hold_bad++;
        end
        if (hold > 0) check({tag, "_hold"}, 64'(hold_bad), 64'd0);
        start_i = 1'b0;
        step();
        check({tag, "_ready_drop"}, 64'(ready_o), 64'd0);
    endtask

    initial begin
        int rise;
        resetn    = 1'b0;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        annul_i   = 1'b0;
        #12;
        check("rst_result", result_o, 64'd0);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        resetn = 1'b1;
        step();

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 0);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 0);
        run_div("divu_big", 1'b0, 32'h8000_0000, 32'd3, {32'h2, 32'h2AAA_AAAA}, 33, 0);
        run_div("div_by0", 1'b1, 32'd5, 32'd0, 64'd0, 2, 0);

        // Annul in the tenth ON cycle.
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        for (int i = 0; i < 10; i++) step();
        annul_i = 1'b1;
        #1;
        check("annul_stall", 64'(stall_o), 64'd0);
        step();
        annul_i = 1'b0;
        start_i = 1'b0;
        rise = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o) rise++;
            step();
        end
        check("annul_no_ready", 64'(rise), 64'd0);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

        // Asynchronous reset mid-operation.
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        for (int i = 0; i < 15; i++) step();
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_result", result_o, 64'd0);
        check("midrst_ready", 64'(ready_o), 64'd0);
        start_i = 1'b0;
        step();
        resetn = 1'b1;
        step();

        run_div("hold", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the execute stage; executes DIV/DIVU.
- Produces the remainder (HI) and quotient (LO) for the HI/LO write path.
- Drives stall_o, which becomes the hazard unit's stall_divE; this freezes fetch, decode and execute while a division is in flight.
- annul_i, driven by the exception flush, aborts an in-flight division.

Parameters:
- WIDTH, 32, operand width; the counter is clog2(WIDTH)+1 bits; the result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start_i  input  1  a divide instruction is in E; held high by the pipeline until ready_o.
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- opdata1_i  input  WIDTH  dividend (rs); sampled with start.
- opdata2_i  input  WIDTH  divisor (rt); sampled with start.
- annul_i  input  1  exception flush; aborts the operation.
- result_o  output  2*WIDTH  {remainder, quotient}; upper half goes to HI, lower half to LO.
- ready_o  output  1  result_o valid this cycle.
- stall_o  output  1  pipeline-freeze request to the hazard unit.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE, count=0, result_o=0, ready_o=0.
  - stall_o follows its combinational equation, so it is 0 while start_i=0.
  - Reset mid-operation discards all progress.
- FSM states: IDLE, DIVZERO, ON, END. All transitions occur on the rising clk edge.
- IDLE:
  - If start_i & ~annul_i and opdata2_i==0, go to DIVZERO.
  - If start_i & ~annul_i and opdata2_i!=0:
    - Latch |dividend| and |divisor|; absolute value only if signed_i, otherwise raw.
    - Latch sign_q = signed_i & (op1[msb]^op2[msb]) and sign_r = signed_i & op1[msb].
    - Clear the partial remainder and set count=0.
    - Go to ON.
  - Otherwise remain in IDLE.
- DIVZERO: store result_o=0 and go to END. This is the defined behaviour for divide-by-zero; no exception is raised.
- ON:
  - Each cycle performs one restoring step: shift {rem, quo} left by 1; if rem >= divisor, subtract and set quo[0]=1; count+1.
  - The step with count==WIDTH-1 is the final one. It applies sign correction (negate quotient if sign_q, negate remainder if sign_r), registers result_o, and goes to END.
  - annul_i=1 in any ON cycle goes to IDLE; result_o is unchanged and ready_o stays 0.
- END:
  - ready_o=1 (registered; high exactly while state==END).
  - If start_i=0 or annul_i=1, go to IDLE and clear ready_o.
  - Otherwise hold END with result_o stable.
- stall_o = start_i & ~annul_i & (state != END), combinational.
  - Consequence: stall_o=0 whenever start_i=0, and drops in the cycle ready_o rises.
  - The hazard unit's exception flush therefore always wins.
- Latency for WIDTH=32:
  - start seen in cycle 0; ON occupies cycles 1..32; END in cycle 33.
  - stall_o high for cycles 0..32 (33 cycles).
  - Divide-by-zero: END in cycle 2, stall_o high for cycles 0..1.
- Arithmetic:
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0 (wrap, no trap).
  - Unsigned operands are never negated.
- A new start while in END with start_i still high is not accepted. The pipeline must drop start_i for at least one cycle (the instruction leaves E), which returns to IDLE. Back-to-back divides therefore have one idle cycle between them.
- Operand inputs are ignored after the start cycle; changes during ON have no effect.

Test Plan:
- Unsigned: start, DIVU, op1=100, op2=7 -> ready_o in cycle 33, result_o={32'd2, 32'd14}; stall_o high cycles 0..32 then 0.
- Signed: DIV op1=0xFFFFFFF9 (-7), op2=2 -> result_o={0xFFFFFFFF, 0xFFFFFFFD}. DIV 7/-2 -> {0x00000001, 0xFFFFFFFD}.
- Overflow and unsigned-large: DIV 0x80000000/0xFFFFFFFF -> {0, 0x80000000}. DIVU 0x80000000/3 -> {0x00000002, 0x2AAAAAAA}.
- Divide by zero: DIV 5/0 -> ready_o in cycle 2, result_o=0, stall_o high only cycles 0..1.
- Abort and reset:
  - annul_i pulse in cycle 10 of ON -> IDLE next edge, ready_o never rises, stall_o=0 in the annul cycle.
  - New DIVU 9/3 afterwards -> {0, 3}.
  - resetn low at cycle 15 -> immediate IDLE, result_o=0, ready_o=0.
- Handshake hold: keep start_i high for 5 cycles after ready_o -> result_o stable and stall_o=0 throughout. Drop start_i -> IDLE and ready_o=0 next edge.
